mx_int_block_encoder: RTL and testbench

// - Streaming MX-INT quantiser: packs wide signed integers (one per beat) into MX blocks of k
//   bit_width-bit elements sharing one scale_width-bit exponent.
// - Producer side of the MX operand interface consumed by the attention/matmul datapath
//   (Q/Kt/V element arrays with per-block scales).
// - Picks the smallest shift that fits the block's widest element, arithmetic-shifts all k

---
 rtl/mx_int_block_encoder.sv | 133 +++++++++++++
 tb/tb_mx_int_block_encoder.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mx_int_block_encoder.sv
// Streaming MX-INT block encoder: gathers k wide signed beats, finds the smallest shift that
// fits the widest element into bit_width bits, and emits the shifted block with a shared exponent.
module mx_int_block_encoder #(
    parameter int k           = 2,
    parameter int in_width    = 16,
    parameter int bit_width   = 8,
    parameter int scale_width = 8
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  logic signed [in_width-1:0]          i_data,
    input  logic        [scale_width-1:0]       i_scale,
    input  logic                                i_last,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic        [k-1:0][bit_width-1:0]  o_data,
    output logic        [scale_width-1:0]       o_scale,
    output logic                                o_last,
    output logic                                o_sat
);

    localparam int cnt_w     = (k > 1) ? $clog2(k) : 1;
    localparam int shift_max = in_width - bit_width;
    localparam int sh_w      = $clog2(shift_max + 1);

    typedef enum logic [1:0] {
        FILL,
        CALC,
        SEND
    } state_t;

    state_t                         state;
    logic        [cnt_w-1:0]        cnt;
    logic signed [in_width-1:0]     slots [k];
    logic        [scale_width-1:0]  scale_q;
    logic                           last_q;

    logic        [sh_w-1:0]         shift_amt;
    logic signed [in_width-1:0]     shifted [k];
    logic        [scale_width:0]    scale_sum;

    // Minimum two's-complement width: one sign bit plus the highest bit that differs from it.
    function automatic int min_width(input logic [in_width-1:0] x);
        logic [in_width-1:0] mag;
        int                  w;
        mag = x[in_width-1] ? ~x : x;
        w   = 1;
        for (int b = 0; b < in_width - 1; b++) begin
            if (mag[b]) w = b + 2;
        end
        return w;
    endfunction

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        int max_w;
        max_w = 1;
        for (int i = 0; i < k; i++) begin
            if (min_width(slots[i]) > max_w) max_w = min_width(slots[i]);
        end
        shift_amt = (max_w > bit_width) ? sh_w'(max_w - bit_width) : '0;
        for (int i = 0; i < k; i++) begin
            shifted[i] = slots[i] >>> shift_amt;
        end
        scale_sum = {1'b0, scale_q} + (scale_width + 1)'(shift_amt);
    end

    // NOTE: the slot array has no reset; the first beat of every block zeroes all slots,
    // so stale or power-up contents can never reach the output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= FILL;
            cnt     <= '0;
            scale_q <= '0;
            last_q  <= 1'b0;
            o_ready <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_scale <= '0;
            o_last  <= 1'b0;
            o_sat   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so all state updates use pre-edge values.
            case (state)
                FILL: begin
                    o_ready <= 1'b1;
                    if (i_valid && o_ready) begin
                        if (cnt == '0) begin
                            for (int i = 0; i < k; i++) slots[i] <= '0;
                            scale_q <= i_scale;
                        end
                        slots[cnt] <= i_data;
                        last_q     <= i_last;
                        if (cnt == cnt_w'(k - 1) || i_last) begin
                            state   <= CALC;
                            o_ready <= 1'b0;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CALC: begin
                    for (int i = 0; i < k; i++) begin
                        o_data[i] <= shifted[i][bit_width-1:0];
                    end
                    o_sat   <= scale_sum[scale_width];
                    o_scale <= scale_sum[scale_width] ? '1 : scale_sum[scale_width-1:0];
                    o_last  <= last_q;
                    o_valid <= 1'b1;
                    state   <= SEND;
                end
                SEND: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        cnt     <= '0;
                        state   <= FILL;
                    end
                end
                default: begin
                    state   <= FILL;
                    o_ready <= 1'b0;
                    o_valid <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mx_int_block_encoder.sv
// Self-checking bench for mx_int_block_encoder (k=2, 16-bit in, 8-bit out, 8-bit exponent):
// directed vectors, latency, backpressure, reset cases and random blocks against a numeric model.
module tb_mx_int_block_encoder;

    localparam int K  = 2;
    localparam int IW = 16;
    localparam int BW = 8;
    localparam int SW = 8;

    logic                      i_clk = 1'b0;
    logic                      i_rst_n;
    logic                      i_valid;
    logic                      o_ready;
    logic signed [IW-1:0]      i_data;
    logic        [SW-1:0]      i_scale;
    logic                      i_last;
    logic                      o_valid;
    logic                      i_ready;
    logic        [K-1:0][BW-1:0] o_data;
    logic        [SW-1:0]      o_scale;
    logic                      o_last;
    logic                      o_sat;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int d0;
        int d1;
        int scale;
        bit sat;
    } exp_t;

    mx_int_block_encoder #(.k(K), .in_width(IW), .bit_width(BW), .scale_width(SW)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_scale (i_scale),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_scale (o_scale),
        .o_last  (o_last),
        .o_sat   (o_sat)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: widths by range test, shifts by floor division.
    function automatic int minw(input int x);
        for (int n = 1; n < 32; n++) begin
            if (x >= -(1 << (n - 1)) && x < (1 << (n - 1))) return n;
        end
        return 32;
    endfunction

    function automatic int floor_div_pow2(input int x, input int s);
        int d;
        d = 1 << s;
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic exp_t model(input int x0, input int x1, input int sc);
        exp_t e;
        int   w;
        int   s;
        int   sum;
        w   = (minw(x0) > minw(x1)) ? minw(x0) : minw(x1);
        s   = (w > BW) ? w - BW : 0;
        e.d0 = floor_div_pow2(x0, s);
        e.d1 = floor_div_pow2(x1, s);
        sum  = sc + s;
        e.sat   = (sum > (1 << SW) - 1);
        e.scale = e.sat ? (1 << SW) - 1 : sum;
        return e;
    endfunction

    // Drive one beat once o_ready is seen; returns #1 after the accepting edge.
    task automatic do_beat(input int data, input int scale, input bit last);
        int g;
        g = 0;
        while (o_ready !== 1'b1 && g < 100) begin
            @(posedge i_clk); #1;
            g++;
        end
        if (g >= 100) begin
            n_cmp++; n_err++;
            $display("FAIL beat_timeout: o_ready=%b, required 1 within 100 cycles", o_ready);
        end
        i_valid = 1'b1;
        i_data  = IW'(data);
        i_scale = SW'(scale);
        i_last  = last;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = IW'($urandom);
        i_scale = SW'($urandom);
    endtask

    // Wait for a block, hold i_ready low for `stall` cycles, then take it.
    task automatic get_block(input int stall, output logic [BW-1:0] d0, output logic [BW-1:0] d1,
                             output logic [SW-1:0] sc, output logic last, output logic sat);
        int g;
        g = 0;
        while (o_valid !== 1'b1 && g < 100) begin
            @(posedge i_clk); #1;
            g++;
        end
        if (g >= 100) begin
            n_cmp++; n_err++;
            $display("FAIL block_timeout: o_valid=%b, required 1 within 100 cycles", o_valid);
        end
        repeat (stall) begin
            @(posedge i_clk); #1;
        end
        d0   = o_data[0];
        d1   = o_data[1];
        sc   = o_scale;
        last = o_last;
        sat  = o_sat;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_scale = '0;
        i_last  = 1'b0;
        i_ready = 1'b0;
        #12;
        n_cmp++;
        if ({o_valid, o_ready, o_last, o_sat} !== 4'b0000 || o_data !== '0 || o_scale !== '0) begin
            n_err++;
            $display("FAIL reset_state: valid/ready/last/sat=%b%b%b%b data=%h scale=%h, required all 0",
                     o_valid, o_ready, o_last, o_sat, o_data, o_scale);
        end
        #11 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        n_cmp++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: ready=%b valid=%b, required 1/0", o_ready, o_valid);
        end
    endtask

    task automatic test_latency();
        do_beat(100, 10, 1'b0);
        do_beat(-50, 99, 1'b0);
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL latency_calc: valid=%b ready=%b one edge after close, required 0/0",
                     o_valid, o_ready);
        end
        @(posedge i_clk); #1;
        n_cmp++;
        if (o_valid !== 1'b1 || int'($signed(o_data[0])) !== 100 || int'($signed(o_data[1])) !== -50
            || o_scale !== 8'd10 || o_sat !== 1'b0 || o_last !== 1'b0) begin
            n_err++;
            $display("FAIL latency_send: valid=%b data=%0d,%0d scale=%0d sat=%b last=%b, required 1 100,-50 10 0 0",
                     o_valid, $signed(o_data[0]), $signed(o_data[1]), o_scale, o_sat, o_last);
        end
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || int'($signed(o_data[0])) !== 100) begin
            n_err++;
            $display("FAIL after_handshake: valid=%b ready=%b data0=%0d, required 0 1 100(held)",
                     o_valid, o_ready, $signed(o_data[0]));
        end
    endtask

    task automatic test_directed();
        // x0, x1, beats, last on final beat, scale, exp d0, exp d1, exp scale, exp last, exp sat
        int vec [6][10] = '{
            '{   100, -50, 2, 0,  10,  100, -50,  10, 0, 0},
            '{  1000,  -3, 2, 0,   5,  125,  -1,   8, 0, 0},
            '{-32768,   0, 2, 0,   0, -128,   0,   8, 0, 0},
            '{   300,   0, 1, 1,   4,   75,   0,   6, 1, 0},
            '{  1000,   0, 2, 0, 254,  125,   0, 255, 0, 1},
            '{   127,-128, 2, 1,   3,  127,-128,   3, 1, 0}
        };
        logic [BW-1:0] d0, d1;
        logic [SW-1:0] sc;
        logic          lst, sat;
        for (int v = 0; v < 6; v++) begin
            if (vec[v][2] == 1) begin
                do_beat(vec[v][0], vec[v][4], 1'b1);
            end else begin
                do_beat(vec[v][0], vec[v][4], 1'b0);
                do_beat(vec[v][1], $urandom_range(0, 255), vec[v][3] != 0);
            end
            get_block(0, d0, d1, sc, lst, sat);
            n_cmp++;
            if (int'($signed(d0)) !== vec[v][5] || int'($signed(d1)) !== vec[v][6] ||
                int'(sc) !== vec[v][7] || int'(lst) !== vec[v][8] || int'(sat) !== vec[v][9]) begin
                n_err++;
                $display("FAIL directed_%0d: data=%0d,%0d scale=%0d last=%b sat=%b, required %0d,%0d %0d %0d %0d",
                         v, $signed(d0), $signed(d1), sc, lst, sat,
                         vec[v][5], vec[v][6], vec[v][7], vec[v][8], vec[v][9]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [K-1:0][BW-1:0] snap_data;
        logic [SW-1:0]        snap_scale;
        logic [BW-1:0]        d0, d1;
        logic [SW-1:0]        sc;
        logic                 lst, sat;
        int                   g;
        do_beat(1000, 5, 1'b0);
        do_beat(-3, 77, 1'b0);
        g = 0;
        while (o_valid !== 1'b1 && g < 20) begin
            @(posedge i_clk); #1;
            g++;
        end
        snap_data  = o_data;
        snap_scale = o_scale;
        n_cmp++;
        if (o_valid !== 1'b1 || int'($signed(snap_data[0])) !== 125 || int'($signed(snap_data[1])) !== -1
            || snap_scale !== 8'd8) begin
            n_err++;
            $display("FAIL bp_block: valid=%b data=%0d,%0d scale=%0d, required 1 125,-1 8",
                     o_valid, $signed(snap_data[0]), $signed(snap_data[1]), snap_scale);
        end
        for (int c = 0; c < 5; c++) begin
            i_valid = 1'b1;
            i_data  = IW'($urandom);
            i_scale = SW'($urandom);
            i_last  = 1'($urandom);
            @(posedge i_clk); #1;
            n_cmp++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data !== snap_data || o_scale !== snap_scale
                || o_last !== 1'b0 || o_sat !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold_%0d: valid=%b ready=%b data=%h scale=%h last=%b sat=%b, required 1 0 %h %h 0 0",
                         c, o_valid, o_ready, o_data, o_scale, o_last, o_sat, snap_data, snap_scale);
            end
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        do_beat(7, 20, 1'b0);
        do_beat(-9, 3, 1'b0);
        get_block(0, d0, d1, sc, lst, sat);
        n_cmp++;
        if (int'($signed(d0)) !== 7 || int'($signed(d1)) !== -9 || sc !== 8'd20 || lst !== 1'b0 || sat !== 1'b0) begin
            n_err++;
            $display("FAIL bp_next_block: data=%0d,%0d scale=%0d last=%b sat=%b, required 7,-9 20 0 0",
                     $signed(d0), $signed(d1), sc, lst, sat);
        end
    endtask

    task automatic test_reset_mid_block();
        logic [BW-1:0] d0, d1;
        logic [SW-1:0] sc;
        logic          lst, sat;
        int            g;
        // Reset while a block is being offered downstream.
        do_beat(1000, 254, 1'b0);
        do_beat(1, 0, 1'b0);
        g = 0;
        while (o_valid !== 1'b1 && g < 20) begin
            @(posedge i_clk); #1;
            g++;
        end
        #2 i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_sat !== 1'b0 || o_scale !== '0 || o_data !== '0) begin
            n_err++;
            $display("FAIL reset_in_send: valid=%b ready=%b sat=%b scale=%0d data=%h, required all 0",
                     o_valid, o_ready, o_sat, o_scale, o_data);
        end
        #2 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        // Reset after the first beat of a block.
        do_beat(99, 50, 1'b0);
        #2 i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_fill: valid=%b ready=%b, required 0/0", o_valid, o_ready);
        end
        #2 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        do_beat(7, 12, 1'b0);
        do_beat(8, 1, 1'b0);
        get_block(1, d0, d1, sc, lst, sat);
        n_cmp++;
        if (int'($signed(d0)) !== 7 || int'($signed(d1)) !== 8 || sc !== 8'd12 || lst !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_stale: data=%0d,%0d scale=%0d last=%b, required 7,8 12 0",
                     $signed(d0), $signed(d1), sc, lst);
        end
    endtask

    task automatic test_random();
        logic [BW-1:0] d0, d1;
        logic [SW-1:0] sc;
        logic          lst, sat;
        exp_t          e;
        int            x [2];
        int            n;
        bit            last;
        int            scale;
        for (int b = 0; b < 60; b++) begin
            n     = $urandom_range(1, 2);
            last  = (n == 1) ? 1'b1 : 1'($urandom);
            scale = ($urandom_range(0, 3) == 0) ? $urandom_range(247, 255) : $urandom_range(0, 255);
            for (int i = 0; i < 2; i++) begin
                int bits;
                bits = $urandom_range(1, IW);
                x[i] = int'($urandom) <<< (32 - bits);
                x[i] = x[i] >>> (32 - bits);
            end
            if (n == 1) x[1] = 0;
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    i_last = 1'($urandom);
                    @(posedge i_clk); #1;
                end
                i_last = 1'b0;
                do_beat(x[i], (i == 0) ? scale : int'($urandom_range(0, 255)), (i == n - 1) && last);
            end
            get_block($urandom_range(0, 3), d0, d1, sc, lst, sat);
            e = model(x[0], x[1], scale);
            n_cmp++;
            if (int'($signed(d0)) !== e.d0 || int'($signed(d1)) !== e.d1 || int'(sc) !== e.scale
                || lst !== last || sat !== e.sat) begin
                n_err++;
                $display("FAIL random_%0d (x=%0d,%0d n=%0d sc=%0d): data=%0d,%0d scale=%0d last=%b sat=%b, required %0d,%0d %0d %b %b",
                         b, x[0], x[1], n, scale, $signed(d0), $signed(d1), sc, lst, sat,
                         e.d0, e.d1, e.scale, last, e.sat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_backpressure();
        test_reset_mid_block();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
